upc_scan_tally: RTL
===================

// Module: upc_scan_tally
// PURPOSE
//  Registered, parametrised UPC checkout classifier. Takes a stream of scanned codes with a
//  valid/ready handshake and flags each one as discounted and/or stolen using per-code mask tables.
//  Keeps saturating tallies and raises a sticky alarm when the stolen count reaches a threshold.
//  Sits between the scanner input sync stage and the checkout display/alarm logic.
// PARAMETERS
//  CODE_W        3      width of a UPC code; table size is 2**CODE_W
//  DISC_MASK     8'hEC  bit k=1 -> code k discounted (default equals P|(U&C) over {U,P,C})
//  EXPN_MASK     8'h31  bit k=1 -> code k expensive; stolen when expensive and unmarked
//  CNT_W         8      width of each tally counter
//  ALARM_THRESH  3      stolen tally value that trips the alarm (1..2**CNT_W-1)
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        asynchronous, active-low reset
//  in_valid   in   1        scanned code present
//  in_ready   out  1        block can accept the code this cycle
//  in_code    in   CODE_W   UPC code
//  in_mark    in   1        security mark present on the item
//  out_valid  out  1        classification result held
//  out_ready  in   1        downstream consumes the result
//  out_code   out  CODE_W   code of the held result
//  out_disc   out  1        held item is discounted
//  out_stolen out  1        held item is stolen
//  tally_items / tally_disc / tally_stolen  out  CNT_W  saturating counts of accepted items
//  alarm      out  1        sticky alarm
//  alarm_ack  in   1        clears the alarm and all tallies
// BEHAVIOUR
//  - Reset: all outputs 0, except in_ready=1. State SCAN. Counters 0. Reset is asynchronous.
//  - Input handshake: a code is accepted on a cycle with in_valid & in_ready.
//  - Result timing: the result appears the next cycle (latency 1) in a single output register.
//  - Output handshake: the held result stays stable while out_valid & ~out_ready.
//  - in_ready = (state==SCAN) & (~out_valid | out_ready): accept and drain in the same cycle.
//  - Classification: disc = DISC_MASK[in_code]; stolen = EXPN_MASK[in_code] & ~in_mark.
//    Both are computed from the codes at acceptance time.
//  - Tallies: on acceptance, tally_items +1; tally_disc +1 if disc; tally_stolen +1 if stolen.
//    Each counter saturates at 2**CNT_W-1 and never wraps.
//  - FSM SCAN -> ALARM: on an acceptance that brings tally_stolen to >= ALARM_THRESH.
//    alarm=1 from the next cycle.
//  - FSM ALARM:
//    - in_ready=0; any held result still drains normally.
//    - ALARM -> SCAN on alarm_ack: tallies cleared, alarm=0 next cycle.
//  - alarm_ack in SCAN: clears the tallies only. If it coincides with an acceptance, the clear wins
//    (tallies=0) but the result is still produced.
//  - Saturation: a saturated tally_stolen that still meets the threshold re-trips the alarm only
//    after the ack has cleared it.
//  - Reset mid-transfer: any held result is discarded (out_valid=0).
// STRUCTURE
//  - Package upc_pkg holds:
//    - typedef code_t;
//    - state enum {SCAN, ALARM};
//    - localparams DISC_MASK_DEF and EXPN_MASK_DEF.
//  - One sub-module sat_counter #(W), instantiated three times.
//    - Ports: clk, reset_n, clr, inc, q.
//    - Increments, holds at max; clr has priority over inc.
//  - Top holds the FSM, the output register and the handshake logic.
// TESTING
//  1. Reset then all 8 codes, mark=1, out_ready=1 -> out_disc=1 exactly for codes 2,3,5,6,7.
//     Tallies: items=8, disc=5.
//  2. out_ready=0 for 4 cycles with code 6 held, in_valid=1 -> in_ready=0; out_code stays 6.
//     Next code accepted on the cycle out_ready rises.
//  3. Code 0, mark=0, three times -> tally_stolen=3, alarm=1 one cycle after the 3rd acceptance.
//     in_ready=0 until alarm_ack; after ack, all tallies 0.
//  4. CNT_W=2, 5 discounted items -> tally_disc goes 1,2,3,3,3 (no wrap).
//  5. reset_n pulsed low mid-stream while out_valid=1 -> out_valid=0 and counters 0 immediately,
//     without waiting for clk.
//  6. alarm_ack on the same cycle as an acceptance in SCAN -> tallies 0; result still valid next cycle.

Source files
------------

// File: rtl/upc_pkg.sv
// Shared types and default mask tables for the UPC scan classifier.
package upc_pkg;

  localparam int CODE_W_DEF = 3;

  typedef logic [CODE_W_DEF-1:0] code_t;

  typedef enum logic {
    SCAN  = 1'b0,
    ALARM = 1'b1
  } state_e;

  // Discount table equals P|(U&C) over code bits {U,P,C}; codes 2,3,5,6,7.
  localparam logic [7:0] DISC_MASK_DEF = 8'hEC;
  // Expensive items: codes 0,4,5.
  localparam logic [7:0] EXPN_MASK_DEF = 8'h31;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear first, then increment unless already at the maximum.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !(&q_q)) begin
      q_d = q_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/upc_scan_tally.sv
// UPC checkout classifier: one-deep registered result stage, saturating
// tallies and a sticky stolen-item alarm.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high.
// in_ready does not depend on in_valid; out_valid does not depend on out_ready,
// and the held result stays stable until it is consumed.
module upc_scan_tally
  import upc_pkg::*;
#(
  parameter int                   CODE_W       = 3,
  parameter logic [2**CODE_W-1:0] DISC_MASK    = DISC_MASK_DEF,
  parameter logic [2**CODE_W-1:0] EXPN_MASK    = EXPN_MASK_DEF,
  parameter int                   CNT_W        = 8,
  parameter int                   ALARM_THRESH = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_mark,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_disc,
  output logic              out_stolen,
  output logic [CNT_W-1:0]  tally_items,
  output logic [CNT_W-1:0]  tally_disc,
  output logic [CNT_W-1:0]  tally_stolen,
  output logic              alarm,
  input  logic              alarm_ack
);

  localparam logic [CNT_W:0] THRESH_EXT = (CNT_W + 1)'(ALARM_THRESH);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic              out_disc_q, out_disc_d;
  logic              out_stolen_q, out_stolen_d;

  logic              accept;
  logic              disc_w;
  logic              stolen_w;
  logic [CNT_W:0]    stolen_plus;

  // Handshake, classification, result register and FSM next-state.
  always_comb begin
    in_ready     = (state_q == SCAN) && (!out_valid_q || out_ready);
    accept       = in_valid && in_ready;
    disc_w       = DISC_MASK[in_code];
    stolen_w     = EXPN_MASK[in_code] && !in_mark;
    // A saturated count plus one still exceeds any legal threshold.
    stolen_plus  = {1'b0, tally_stolen} + {{CNT_W{1'b0}}, 1'b1};

    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    out_disc_d   = out_disc_q;
    out_stolen_d = out_stolen_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_code_d   = in_code;
      out_disc_d   = disc_w;
      out_stolen_d = stolen_w;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      SCAN: begin
        // A coincident ack clears the tallies, so it also suppresses the trip.
        if (accept && stolen_w && !alarm_ack && (stolen_plus >= THRESH_EXT)) begin
          state_d = ALARM;
        end
      end
      ALARM: begin
        if (alarm_ack) begin
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SCAN;
      out_valid_q  <= 1'b0;
      out_code_q   <= '0;
      out_disc_q   <= 1'b0;
      out_stolen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
      out_disc_q   <= out_disc_d;
      out_stolen_q <= out_stolen_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_items (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (alarm_ack),
    .inc     (accept),
    .q       (tally_items)
  );

  sat_counter #(.W(CNT_W)) u_cnt_disc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (alarm_ack),
    .inc     (accept && disc_w),
    .q       (tally_disc)
  );

  sat_counter #(.W(CNT_W)) u_cnt_stolen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (alarm_ack),
    .inc     (accept && stolen_w),
    .q       (tally_stolen)
  );

  assign out_valid  = out_valid_q;
  assign out_code   = out_code_q;
  assign out_disc   = out_disc_q;
  assign out_stolen = out_stolen_q;
  assign alarm      = (state_q == ALARM);

endmodule
